// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive safety checker for the red/yellow/green outputs of a traffic light
// controller. It follows the phase sequence RED -> GREEN -> YELLOW -> RED,
// measures how long each phase lasts, and flags illegal encodings,
// out-of-order colours and phase-duration errors. It never drives the
// controller.
//
// Parameters:
//   RED_TIME, GREEN_TIME, YELLOW_TIME - required phase lengths in clk cycles
//   CNT_W                             - run-length counter width; must hold
//                                       max(*_TIME)+1
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   red          in   red light under observation
//   yellow       in   yellow light under observation
//   green        in   green light under observation
//   phase        out  tracked phase: 0 WAIT, 1 RED, 2 GREEN, 3 YELLOW
//   err_illegal  out  one-cycle pulse: encoding not one-hot
//   err_order    out  one-cycle pulse: legal colour out of sequence
//   err_timing   out  one-cycle pulse: phase too short or too long
//   error        out  sticky OR of all pulses, cleared only by reset
//   err_count    out  cycles carrying any pulse, saturating at 255
//   cycles       out  completed YELLOW->RED transitions, wraps at 2^16
//   last_len     out  length of the most recently exited phase
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int RED_TIME    = 10,
    parameter int GREEN_TIME  = 8,
    parameter int YELLOW_TIME = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic [1:0]       phase,
    output logic             err_illegal,
    output logic             err_order,
    output logic             err_timing,
    output logic             error,
    output logic [7:0]       err_count,
    output logic [15:0]      cycles,
    output logic [CNT_W-1:0] last_len
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_RED    = 2'd1;
    localparam logic [1:0] ST_GREEN  = 2'd2;
    localparam logic [1:0] ST_YELLOW = 2'd3;

    localparam logic [CNT_W-1:0] RED_LEN    = CNT_W'(RED_TIME);
    localparam logic [CNT_W-1:0] GREEN_LEN  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] YELLOW_LEN = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] RUN_ONE    = CNT_W'(1);

    logic [1:0]       state_q,       state_d;
    logic             chk_q,         chk_d;
    logic [CNT_W-1:0] run_q,         run_d;
    logic [CNT_W-1:0] last_len_q,    last_len_d;
    logic [15:0]      cycles_q,      cycles_d;
    logic [7:0]       err_count_q,   err_count_d;
    logic             error_q,       error_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_order_q,   err_order_d;
    logic             err_timing_q,  err_timing_d;

    logic [1:0]       sample_state;   // ST_WAIT doubles as "not one-hot"
    logic [1:0]       expected_state;
    logic [CNT_W-1:0] phase_len;
    logic [CNT_W-1:0] run_inc;
    logic             any_pulse;

    // Decode the sampled lights, the legal successor of the current phase and
    // the required length of the current phase.
    always_comb begin
        unique case ({red, yellow, green})
            3'b100:  sample_state = ST_RED;
            3'b010:  sample_state = ST_YELLOW;
            3'b001:  sample_state = ST_GREEN;
            default: sample_state = ST_WAIT;
        endcase

        unique case (state_q)
            ST_RED:    begin expected_state = ST_GREEN;  phase_len = RED_LEN;    end
            ST_GREEN:  begin expected_state = ST_YELLOW; phase_len = GREEN_LEN;  end
            ST_YELLOW: begin expected_state = ST_RED;    phase_len = YELLOW_LEN; end
            default:   begin expected_state = ST_WAIT;   phase_len = '0;         end
        endcase

        run_inc = (run_q == '1) ? run_q : run_q + RUN_ONE;
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        chk_d         = chk_q;
        run_d         = run_q;
        last_len_d    = last_len_q;
        cycles_d      = cycles_q;
        err_illegal_d = 1'b0;
        err_order_d   = 1'b0;
        err_timing_d  = 1'b0;

        if (state_q == ST_WAIT) begin
            // First observed phase is partial, so it is never timing-checked.
            if (sample_state != ST_WAIT) begin
                state_d = sample_state;
                chk_d   = 1'b0;
                run_d   = RUN_ONE;
            end
        end else if (sample_state == ST_WAIT) begin
            // Illegal encoding: drop the phase without measuring it.
            err_illegal_d = 1'b1;
            state_d       = ST_WAIT;
            chk_d         = 1'b0;
            run_d         = '0;
        end else if (sample_state == state_q) begin
            run_d = run_inc;
            // Overrun is reported once; clearing chk suppresses a second
            // report when the phase finally exits.
            if (chk_q && (run_inc == phase_len + RUN_ONE)) begin
                err_timing_d = 1'b1;
                chk_d        = 1'b0;
            end
        end else begin
            // Any colour change ends the phase. The exiting phase is checked
            // even on an order error, so underrun and order can coincide.
            last_len_d = run_q;
            if (chk_q && (run_q != phase_len)) begin
                err_timing_d = 1'b1;
            end
            state_d = sample_state;
            run_d   = RUN_ONE;
            if (sample_state == expected_state) begin
                chk_d = 1'b1;
                if (state_q == ST_YELLOW) begin
                    cycles_d = cycles_q + 16'd1;
                end
            end else begin
                err_order_d = 1'b1;
                chk_d       = 1'b0;
            end
        end
    end

    // Pulses are counted per cycle, not per pulse.
    assign any_pulse   = err_illegal_d | err_order_d | err_timing_d;
    assign error_d     = error_q | any_pulse;
    assign err_count_d = (any_pulse && (err_count_q != 8'hFF)) ? err_count_q + 8'd1
                                                                : err_count_q;

    always_ff @(posedge clk) begin
        // NOTE: reset is only looked at on the clock edge, so it sits inside
        // the clocked branch rather than in the sensitivity list.
        if (!reset) begin
            state_q       <= ST_WAIT;
            chk_q         <= 1'b0;
            run_q         <= '0;
            last_len_q    <= '0;
            cycles_q      <= '0;
            err_count_q   <= '0;
            error_q       <= 1'b0;
            err_illegal_q <= 1'b0;
            err_order_q   <= 1'b0;
            err_timing_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop update from the
            // values present before the edge, independent of statement order.
            state_q       <= state_d;
            chk_q         <= chk_d;
            run_q         <= run_d;
            last_len_q    <= last_len_d;
            cycles_q      <= cycles_d;
            err_count_q   <= err_count_d;
            error_q       <= error_d;
            err_illegal_q <= err_illegal_d;
            err_order_q   <= err_order_d;
            err_timing_q  <= err_timing_d;
        end
    end

    assign phase       = state_q;
    assign err_illegal = err_illegal_q;
    assign err_order   = err_order_q;
    assign err_timing  = err_timing_q;
    assign error       = error_q;
    assign err_count   = err_count_q;
    assign cycles      = cycles_q;
    assign last_len    = last_len_q;

endmodule
